// File: rtl/move_arbiter.sv
// move_arbiter
//   Collision and lock controller for the falling piece. It answers the
//   movement handshake, performs four occupancy reads per request through
//   the single playfield port, decides commit or decline, and on a blocked
//   gravity move writes the last committed piece into the playfield before
//   handing control back for a respawn.
//
//   Optional feature macro: MOVE_ARB_LINE_SCAN_EN
//     defined   : after a lock, each distinct locked row is read back and a
//                 full row is reported on line_full/line_row.
//     undefined : lock goes straight to steal; line_full/line_row are 0.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   movement_request/intent    handshake in (intent 0 = gravity, 1 = player)
//   P1..P4blk_h / P1..P4blk_v  proposed block coordinates (row h, column v)
//   volatile_blk_color         colour written on lock
//   movement_commit            single-cycle accept pulse
//   movement_declined          reject level, held until request drops
//   movement_steal             lock level, held until request drops
//   pf_rd_*                    playfield read port (data one cycle later)
//   pf_wr_*                    playfield write port
//   line_full, line_row        full-row report
//   game_over                  sticky, set when the spawn position is blocked
module move_arbiter #(
  parameter int FIELD_ROWS = 20,
  parameter int FIELD_COLS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       movement_request,
  input  logic       movement_intent,
  input  logic [4:0] P1blk_v,
  input  logic [4:0] P2blk_v,
  input  logic [4:0] P3blk_v,
  input  logic [4:0] P4blk_v,
  input  logic [4:0] P1blk_h,
  input  logic [4:0] P2blk_h,
  input  logic [4:0] P3blk_h,
  input  logic [4:0] P4blk_h,
  input  logic [2:0] volatile_blk_color,
  output logic       movement_commit,
  output logic       movement_declined,
  output logic       movement_steal,
  output logic       pf_rd_en,
  output logic [4:0] pf_rd_row,
  output logic [4:0] pf_rd_col,
  input  logic       pf_rd_data,
  output logic       pf_wr_en,
  output logic [4:0] pf_wr_row,
  output logic [4:0] pf_wr_col,
  output logic [2:0] pf_wr_color,
  output logic       line_full,
  output logic [4:0] line_row,
  output logic       game_over
);

  typedef enum logic [3:0] {
    IDLE, CHECK, COMMIT, DECLINE, LOCK, SCAN, STEAL, WAIT_DROP, DEAD
  } state_t;

  state_t     state_reg;
  logic [2:0] cnt_reg;
  logic [4:0] in_h [4];
  logic [4:0] in_v [4];
  logic [4:0] lat_h_reg [4];
  logic [4:0] lat_v_reg [4];
  logic [4:0] com_h_reg [4];
  logic [4:0] com_v_reg [4];
  logic       intent_reg;
  logic       blocked_reg;
  logic       rd_pend_reg;
  logic       committed_valid_reg;
  logic       commit_reg;
  logic       declined_reg;
  logic       steal_reg;
  logic       game_over_reg;
  logic       rd_en_reg;
  logic [4:0] rd_row_reg;
  logic [4:0] rd_col_reg;
  logic       wr_en_reg;
  logic [4:0] wr_row_reg;
  logic [4:0] wr_col_reg;
  logic [2:0] wr_color_reg;
  logic       check_hit;

  assign in_h[0] = P1blk_h;
  assign in_h[1] = P2blk_h;
  assign in_h[2] = P3blk_h;
  assign in_h[3] = P4blk_h;
  assign in_v[0] = P1blk_v;
  assign in_v[1] = P2blk_v;
  assign in_v[2] = P3blk_v;
  assign in_v[3] = P4blk_v;

  // Coordinates are unsigned: a wrap below zero lands at 31 and fails here.
  function automatic logic oob(input logic [4:0] h, input logic [4:0] v);
    return (int'(h) >= FIELD_ROWS) || (int'(v) >= FIELD_COLS);
  endfunction

  // rd_pend_reg marks that the data arriving now belongs to a real read,
  // so skipped (out-of-bounds) slots never contribute stale data.
  assign check_hit = blocked_reg | (rd_pend_reg & pf_rd_data);

`ifdef MOVE_ARB_LINE_SCAN_EN
  localparam int CW = $clog2(FIELD_COLS + 1);
  logic [2:0]    scan_blk_reg;
  logic [4:0]    scan_row_reg;
  logic [CW-1:0] col_cnt_reg;
  logic          full_reg;
  logic          eval_reg;
  logic [3:0]    dup;
  logic [2:0]    next_blk;

  // dup[j]: block j sits on a row already owned by an earlier block.
  assign dup[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_dup
      always_comb begin
        dup[gi] = 1'b0;
        for (int i = 0; i < gi; i++)
          if (com_h_reg[i] == com_h_reg[gi]) dup[gi] = 1'b1;
      end
    end
  endgenerate

  // Next block after the current one whose row has not been scanned; 4 = done.
  always_comb begin
    next_blk = 3'd4;
    for (int j = 3; j >= 1; j--)
      if (j > int'(scan_blk_reg) && !dup[j]) next_blk = 3'(j);
  end

  // The last column's data arrives in the evaluation cycle itself, so the
  // pulse combines the registered accumulator with the incoming read data.
  assign line_full = eval_reg & full_reg & pf_rd_data;
  assign line_row  = line_full ? scan_row_reg : 5'd0;
`else
  assign line_full = 1'b0;
  assign line_row  = 5'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg           <= IDLE;
      cnt_reg             <= '0;
      intent_reg          <= 1'b0;
      blocked_reg         <= 1'b0;
      rd_pend_reg         <= 1'b0;
      committed_valid_reg <= 1'b0;
      commit_reg          <= 1'b0;
      declined_reg        <= 1'b0;
      steal_reg           <= 1'b0;
      game_over_reg       <= 1'b0;
      rd_en_reg           <= 1'b0;
      rd_row_reg          <= '0;
      rd_col_reg          <= '0;
      wr_en_reg           <= 1'b0;
      wr_row_reg          <= '0;
      wr_col_reg          <= '0;
      wr_color_reg        <= '0;
      for (int i = 0; i < 4; i++) begin
        lat_h_reg[i] <= '0;
        lat_v_reg[i] <= '0;
        com_h_reg[i] <= '0;
        com_v_reg[i] <= '0;
      end
`ifdef MOVE_ARB_LINE_SCAN_EN
      scan_blk_reg <= '0;
      scan_row_reg <= '0;
      col_cnt_reg  <= '0;
      full_reg     <= 1'b0;
      eval_reg     <= 1'b0;
`endif
    end else begin
      rd_pend_reg <= rd_en_reg;
      case (state_reg)
        IDLE: begin
          if (movement_request) begin
            for (int i = 0; i < 4; i++) begin
              lat_h_reg[i] <= in_h[i];
              lat_v_reg[i] <= in_v[i];
            end
            intent_reg  <= movement_intent;
            // Slot 1 is issued straight from the ports on the accepting edge.
            rd_en_reg   <= !oob(in_h[0], in_v[0]);
            rd_row_reg  <= in_h[0];
            rd_col_reg  <= in_v[0];
            blocked_reg <= oob(in_h[0], in_v[0]);
            cnt_reg     <= 3'd1;
            state_reg   <= CHECK;
          end
        end

        CHECK: begin
          if (!movement_request) begin
            rd_en_reg <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg <= 3'd3) begin
              rd_en_reg   <= !oob(lat_h_reg[cnt_reg[1:0]], lat_v_reg[cnt_reg[1:0]]);
              rd_row_reg  <= lat_h_reg[cnt_reg[1:0]];
              rd_col_reg  <= lat_v_reg[cnt_reg[1:0]];
              blocked_reg <= check_hit | oob(lat_h_reg[cnt_reg[1:0]], lat_v_reg[cnt_reg[1:0]]);
            end else if (cnt_reg == 3'd4) begin
              rd_en_reg   <= 1'b0;
              blocked_reg <= check_hit;
            end else if (!check_hit) begin
              for (int i = 0; i < 4; i++) begin
                com_h_reg[i] <= lat_h_reg[i];
                com_v_reg[i] <= lat_v_reg[i];
              end
              committed_valid_reg <= 1'b1;
              commit_reg          <= 1'b1;
              state_reg           <= COMMIT;
            end else if (intent_reg) begin
              declined_reg <= 1'b1;
              state_reg    <= DECLINE;
            end else if (committed_valid_reg) begin
              wr_en_reg    <= 1'b1;
              wr_row_reg   <= com_h_reg[0];
              wr_col_reg   <= com_v_reg[0];
              wr_color_reg <= volatile_blk_color;
              cnt_reg      <= 3'd1;
              state_reg    <= LOCK;
            end else begin
              // A gravity move with nothing committed is the spawn position.
              game_over_reg <= 1'b1;
              state_reg     <= DEAD;
            end
          end
        end

        COMMIT: begin
          commit_reg <= 1'b0;
          state_reg  <= WAIT_DROP;
        end

        WAIT_DROP: begin
          if (!movement_request) state_reg <= IDLE;
        end

        DECLINE: begin
          if (!movement_request) begin
            declined_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        LOCK: begin
          if (cnt_reg <= 3'd3) begin
            wr_en_reg    <= 1'b1;
            wr_row_reg   <= com_h_reg[cnt_reg[1:0]];
            wr_col_reg   <= com_v_reg[cnt_reg[1:0]];
            wr_color_reg <= volatile_blk_color;
            cnt_reg      <= cnt_reg + 3'd1;
          end else begin
            wr_en_reg <= 1'b0;
`ifdef MOVE_ARB_LINE_SCAN_EN
            // Block 1's row is always new; its first read overlaps nothing
            // because the write enable drops on this same edge.
            scan_blk_reg <= 3'd0;
            scan_row_reg <= com_h_reg[0];
            rd_en_reg    <= 1'b1;
            rd_row_reg   <= com_h_reg[0];
            rd_col_reg   <= 5'd0;
            col_cnt_reg  <= CW'(1);
            full_reg     <= 1'b1;
            state_reg    <= SCAN;
`else
            steal_reg <= 1'b1;
            state_reg <= STEAL;
`endif
          end
        end

`ifdef MOVE_ARB_LINE_SCAN_EN
        SCAN: begin
          if (eval_reg) begin
            eval_reg <= 1'b0;
            if (next_blk == 3'd4) begin
              steal_reg <= 1'b1;
              state_reg <= STEAL;
            end else begin
              scan_blk_reg <= next_blk;
              scan_row_reg <= com_h_reg[next_blk[1:0]];
              rd_en_reg    <= 1'b1;
              rd_row_reg   <= com_h_reg[next_blk[1:0]];
              rd_col_reg   <= 5'd0;
              col_cnt_reg  <= CW'(1);
              full_reg     <= 1'b1;
            end
          end else begin
            full_reg <= full_reg & (pf_rd_data | ~rd_pend_reg);
            if (int'(col_cnt_reg) < FIELD_COLS) begin
              rd_en_reg   <= 1'b1;
              rd_col_reg  <= 5'(col_cnt_reg);
              col_cnt_reg <= col_cnt_reg + 1'b1;
            end else begin
              rd_en_reg <= 1'b0;
              eval_reg  <= 1'b1;
            end
          end
        end
`endif

        STEAL: begin
          if (!movement_request) begin
            steal_reg           <= 1'b0;
            committed_valid_reg <= 1'b0;
            state_reg           <= IDLE;
          end
        end

        DEAD: begin
          // Terminal until reset.
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign movement_commit   = commit_reg;
  assign movement_declined = declined_reg;
  assign movement_steal    = steal_reg;
  assign game_over         = game_over_reg;
  assign pf_rd_en          = rd_en_reg;
  assign pf_rd_row         = rd_row_reg;
  assign pf_rd_col         = rd_col_reg;
  assign pf_wr_en          = wr_en_reg;
  assign pf_wr_row         = wr_row_reg;
  assign pf_wr_col         = wr_col_reg;
  assign pf_wr_color       = wr_color_reg;

endmodule
